// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU codes, mux selects, opcodes.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    // Only arithmetic results produce meaningful carry/overflow flags.
    function automatic logic is_arith(input logic [1:0] alu_control);
        return (alu_control == ALU_ADD) || (alu_control == ALU_SUB);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the data-processing command to an ALU operation, flag-write enables
// and the register-write suppression used by compare instructions.
module mc_aludec
    import mc_pkg::*;
(
    input  logic       i_alu_op,
    input  logic [1:0] i_op,
    input  logic [5:0] i_funct,
    output logic [1:0] o_alu_control,
    output logic [1:0] o_flag_w,
    output logic       o_no_write
);

    logic [3:0] w_cmd;
    assign w_cmd = i_funct[4:1];

    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves it unassigned (no latch).
        o_alu_control = ALU_ADD;
        o_flag_w      = 2'b00;
        if (i_alu_op) begin
            case (w_cmd)
                CMD_ADD: o_alu_control = ALU_ADD;
                CMD_SUB: o_alu_control = ALU_SUB;
                CMD_AND: o_alu_control = ALU_AND;
                CMD_ORR: o_alu_control = ALU_ORR;
                CMD_CMP: o_alu_control = ALU_SUB;
                default: o_alu_control = ALU_ADD;
            endcase
            o_flag_w[1] = i_funct[0];
            o_flag_w[0] = i_funct[0] & is_arith(o_alu_control);
        end
    end

    assign o_no_write = (i_op == OP_DP) && (w_cmd == CMD_CMP);

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller FSM with ALU decode; MC_CONTROLLER_BL_EN enables the
// branch-with-link register write (LinkW), otherwise LinkW is tied low.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       LinkW
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_alu_op;
    logic       w_branch;
    logic       w_reg_w;
    logic       w_no_write;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so all flops sample the same pre-edge values.
        if (reset) r_state <= FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = FETCH;
        NextPC       = 1'b0;
        w_reg_w      = 1'b0;
        MemW         = 1'b0;
        IRWrite      = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_REG;
        ALUSrcB      = SRCB_REG;
        w_alu_op     = 1'b0;
        w_branch     = 1'b0;
        case (r_state)
            FETCH: begin
                w_next_state = DECODE;
                IRWrite      = 1'b1;
                NextPC       = 1'b1;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
            end
            DECODE: begin
                case (Op)
                    OP_MEM:  w_next_state = MEMADR;
                    OP_DP:   w_next_state = Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   w_next_state = BRANCH;
                    default: w_next_state = UNKNOWN;
                endcase
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR: begin
                w_next_state = Funct[0] ? MEMRD : MEMWR;
                ALUSrcB      = SRCB_IMM;
            end
            MEMRD: begin
                w_next_state = MEMWB;
                AdrSrc       = 1'b1;
            end
            MEMWB: begin
                w_reg_w   = 1'b1;
                ResultSrc = RES_DATA;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: begin
                w_next_state = ALUWB;
                w_alu_op     = 1'b1;
            end
            EXECUTEI: begin
                w_next_state = ALUWB;
                ALUSrcB      = SRCB_IMM;
                w_alu_op     = 1'b1;
            end
            ALUWB: begin
                // Compares update flags only; the destination register is left untouched.
                w_reg_w = ~w_no_write;
            end
            BRANCH: begin
                w_branch  = 1'b1;
                ALUSrcA   = SRCA_ALUOUT;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
            end
            default: w_next_state = FETCH;
        endcase
    end

    mc_aludec u_aludec (
        .i_alu_op      (w_alu_op),
        .i_op          (Op),
        .i_funct       (Funct),
        .o_alu_control (ALUControl),
        .o_flag_w      (FlagW),
        .o_no_write    (w_no_write)
    );

    assign RegW = w_reg_w;
    assign PCS  = ((Rd == 4'hF) & w_reg_w) | w_branch;

`ifdef MC_CONTROLLER_BL_EN
    assign LinkW = w_branch & Funct[4];
`else
    assign LinkW = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instructions, random instructions and a
// mid-load reset, compared cycle by cycle against an instruction-level reference model.
module tb_mc_controller;

    typedef struct packed {
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       pcs;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_control;
        logic [1:0] flag_w;
        logic       link_w;
    } out_t;

`ifdef MC_CONTROLLER_BL_EN
    localparam bit BL_EN = 1'b1;
`else
    localparam bit BL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       NextPC, RegW, MemW, PCS, IRWrite, AdrSrc, LinkW;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUControl, FlagW;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .NextPC     (NextPC),
        .RegW       (RegW),
        .MemW       (MemW),
        .PCS        (PCS),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .LinkW      (LinkW)
    );

    // ALU operation implied by a data-processing command field.
    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'd4:    return 2'd0;
            4'd2:    return 2'd1;
            4'd0:    return 2'd2;
            4'd12:   return 2'd3;
            4'd10:   return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // Number of cycles an instruction occupies, FETCH included.
    function automatic int latency(input logic [1:0] op, input logic [5:0] funct);
        if (op == 2'd0) return 4;
        if (op == 2'd1) return funct[0] ? 5 : 4;
        return 3;
    endfunction

    // Expected outputs in cycle k of an instruction (k=0 is its fetch cycle).
    function automatic out_t model(input logic [1:0] op, input logic [5:0] funct,
                                   input logic [3:0] rd, input int k);
        out_t       e;
        logic [1:0] ctl;
        logic       s;
        e   = '0;
        ctl = alu_of(funct[4:1]);
        s   = funct[0];
        if (k == 0) begin
            e.ir_write   = 1'b1;
            e.next_pc    = 1'b1;
            e.alu_src_a  = 2'd1;
            e.alu_src_b  = 2'd2;
            e.result_src = 2'd2;
        end else if (k == 1) begin
            e.alu_src_a  = 2'd1;
            e.alu_src_b  = 2'd2;
            e.result_src = 2'd2;
        end else begin
            case (op)
                2'd0: begin
                    if (k == 2) begin
                        e.alu_src_b   = funct[5] ? 2'd1 : 2'd0;
                        e.alu_control = ctl;
                        e.flag_w      = {s, s & (ctl < 2'd2)};
                    end else begin
                        e.reg_w = (funct[4:1] != 4'd10);
                        e.pcs   = e.reg_w & (rd == 4'd15);
                    end
                end
                2'd1: begin
                    if (k == 2) begin
                        e.alu_src_b = 2'd1;
                    end else if (k == 3) begin
                        e.adr_src = 1'b1;
                        e.mem_w   = ~funct[0];
                    end else begin
                        e.reg_w      = 1'b1;
                        e.result_src = 2'd1;
                        e.pcs        = (rd == 4'd15);
                    end
                end
                2'd2: begin
                    e.pcs        = 1'b1;
                    e.alu_src_a  = 2'd2;
                    e.alu_src_b  = 2'd1;
                    e.result_src = 2'd2;
                    e.link_w     = BL_EN & funct[4];
                end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input out_t exp);
        out_t obs;
        obs.next_pc     = NextPC;
        obs.reg_w       = RegW;
        obs.mem_w       = MemW;
        obs.pcs         = PCS;
        obs.ir_write    = IRWrite;
        obs.adr_src     = AdrSrc;
        obs.result_src  = ResultSrc;
        obs.alu_src_a   = ALUSrcA;
        obs.alu_src_b   = ALUSrcB;
        obs.alu_control = ALUControl;
        obs.flag_w      = FlagW;
        obs.link_w      = LinkW;
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Runs one instruction from its FETCH cycle; entered and left 1 ns after a rising edge.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input int max_cycles);
        int n;
        Op    = op;
        Funct = funct;
        Rd    = rd;
        n = latency(op, funct);
        if (max_cycles < n) n = max_cycles;
        for (int k = 0; k < n; k++) begin
            #3;
            check($sformatf("op=%b funct=%b rd=%h cyc%0d", op, funct, rd, k),
                  model(op, funct, rd, k));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        Op    = 2'd0;
        Funct = 6'd0;
        Rd    = 4'd0;

        #2;
        check("reset_fetch", model(2'd0, 6'd0, 4'd0, 0));
        @(posedge clk);
        #1;
        check("reset_held_fetch", model(2'd0, 6'd0, 4'd0, 0));
        reset = 1'b0;

        run_instr(2'b00, 6'b001000, 4'b0011, 99);   // ADD register
        run_instr(2'b00, 6'b100101, 4'b0010, 99);   // SUBS immediate
        run_instr(2'b00, 6'b010101, 4'b0000, 99);   // CMP register
        run_instr(2'b00, 6'b110101, 4'b1111, 99);   // CMP immediate to r15: no PCS
        run_instr(2'b00, 6'b011001, 4'b0100, 99);   // ORRS
        run_instr(2'b00, 6'b000001, 4'b0101, 99);   // ANDS: logical, carry flags untouched
        run_instr(2'b00, 6'b101000, 4'b1111, 99);   // ADD immediate to PC
        run_instr(2'b00, 6'b011111, 4'b0001, 99);   // unlisted command decodes as add
        run_instr(2'b01, 6'b000001, 4'b1111, 99);   // LDR to PC
        run_instr(2'b01, 6'b000000, 4'b0110, 99);   // STR
        run_instr(2'b10, 6'b000000, 4'b0000, 99);   // B
        run_instr(2'b10, 6'b010000, 4'b1110, 99);   // BL
        run_instr(2'b11, 6'b111111, 4'b1111, 99);   // undefined

        // Abort a load in MEMRD with an asynchronous reset pulse.
        run_instr(2'b01, 6'b011001, 4'b1111, 3);
        #2;
        check("ldr_memrd_before_abort", model(2'b01, 6'b011001, 4'b1111, 3));
        reset = 1'b1;
        #1;
        check("abort_async_fetch", model(2'b00, 6'd0, 4'd0, 0));
        @(posedge clk);
        #1;
        check("abort_held_fetch", model(2'b00, 6'd0, 4'd0, 0));
        #3;
        check("abort_held_fetch_mid", model(2'b00, 6'd0, 4'd0, 0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(2'b00, 6'b001000, 4'b0111, 99);   // resumes cleanly from FETCH

        for (int i = 0; i < 40; i++) begin
            run_instr(2'($urandom_range(0, 3)), 6'($urandom()), 4'($urandom()), 99);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
